// File: rtl/timer_pkg.sv
// Shared definitions for the timer interrupt path: FSM encoding and source limits.
package timer_pkg;

  localparam int TIMER_IRQ_PULSE_LEN = 16;
  localparam int TIMER_MAX_SRC       = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/timer_irq_prio.sv
// Fixed-priority encoder: the lowest set index of cand wins.
module timer_irq_prio
  import timer_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] cand,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // scan from the top down so the lowest candidate is written last
  always_comb begin
    valid = |cand;
    id    = {ID_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      id = cand[i] ? ID_W'(i) : id;
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: edge-detected sticky pending bits, enable mask, fixed-priority
// request with ack/eoi handshake. Define TIMER_IRQ_SYNC_EN to add a 2-flop input synchronizer.
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             en_wr,
  input  logic [N_SRC-1:0] en_wdata,
  input  logic             clr_wr,
  input  logic [N_SRC-1:0] clr_wdata,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq_out,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overflow,
  output logic [N_SRC-1:0] enable
);

  irq_state_t       state_r;
  logic             irq_out_r;
  logic [ID_W-1:0]  irq_id_r;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] overflow_r;
  logic [N_SRC-1:0] enable_r;
  logic [N_SRC-1:0] irq_d_r;

  logic [N_SRC-1:0] irq_s;
  logic [N_SRC-1:0] rise_s;
  logic [N_SRC-1:0] wclr_s;
  logic [N_SRC-1:0] aclr_s;
  logic [N_SRC-1:0] clr_all_s;
  logic [N_SRC-1:0] id_oh_s;
  logic [N_SRC-1:0] pending_nxt_s;
  logic [N_SRC-1:0] overflow_nxt_s;
  logic [N_SRC-1:0] cand_s;
  logic             keep_s;
  logic             prio_valid_s;
  logic [ID_W-1:0]  prio_id_s;

`ifdef TIMER_IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_r;
  logic [N_SRC-1:0] sync2_r;

  // two-flop synchronizer for sources running on a foreign clock
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= {N_SRC{1'b0}};
      sync2_r <= {N_SRC{1'b0}};
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
    end
  end

  assign irq_s = sync2_r;
`else
  assign irq_s = irq_in;
`endif

  // next-state of the sticky bits; a set always beats a clear on the same bit
  always_comb begin
    rise_s         = irq_s & ~irq_d_r;
    wclr_s         = clr_wr ? clr_wdata : {N_SRC{1'b0}};
    id_oh_s        = {{(N_SRC-1){1'b0}}, 1'b1} << irq_id_r;
    aclr_s         = ((state_r == REQ) && ack) ? id_oh_s : {N_SRC{1'b0}};
    clr_all_s      = wclr_s | aclr_s;
    pending_nxt_s  = (pending_r & ~clr_all_s) | rise_s;
    overflow_nxt_s = (overflow_r & ~wclr_s) | (rise_s & pending_r & ~clr_all_s);
    cand_s         = pending_r & enable_r;
    keep_s         = |(cand_s & id_oh_s);
  end

  timer_irq_prio #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .cand  (cand_s),
    .valid (prio_valid_s),
    .id    (prio_id_s)
  );

  // edge detector history plus pending/overflow/enable registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_d_r    <= {N_SRC{1'b0}};
      pending_r  <= {N_SRC{1'b0}};
      overflow_r <= {N_SRC{1'b0}};
      enable_r   <= {N_SRC{1'b0}};
    end else begin
      irq_d_r    <= irq_s;
      pending_r  <= pending_nxt_s;
      overflow_r <= overflow_nxt_s;
      enable_r   <= en_wr ? en_wdata : enable_r;
    end
  end

  // request/ack/eoi handshake; the FSM decides from registered pending/enable only
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      irq_out_r <= 1'b0;
      irq_id_r  <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (prio_valid_s) begin
            state_r   <= REQ;
            irq_out_r <= 1'b1;
            irq_id_r  <= prio_id_s;
          end else begin
            irq_out_r <= 1'b0;
          end
        end
        REQ: begin
          if (ack) begin
            state_r   <= SERVICE;
            irq_out_r <= 1'b0;
          end else if (!keep_s) begin
            state_r   <= IDLE;
            irq_out_r <= 1'b0;
          end else begin
            irq_out_r <= 1'b1;
          end
        end
        SERVICE: begin
          irq_out_r <= 1'b0;
          if (eoi) begin
            state_r <= IDLE;
          end else begin
            state_r <= SERVICE;
          end
        end
        default: begin
          state_r   <= IDLE;
          irq_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign irq_out  = irq_out_r;
  assign irq_id   = irq_id_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;
  assign enable   = enable_r;

endmodule
